// File: rtl/stream_host_pkg.sv
// stream_host_pkg
//   Shared types and sizing helpers for the stream_host block.
//   - state_t    : controller states
//   - DATA_W_DEF : default word width
//   - cnt_w()    : width needed to hold a count of 0..n
//   - idx_w()    : width needed to index n entries (at least 1)
package stream_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_REPORT
  } state_t;

  localparam int DATA_W_DEF = 16;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_host_buf.sv
// stream_host_buf
//   Word buffer: DEPTH x DATA_W register file, one synchronous write port and
//   two combinational read ports (transmit index and compare index).
//   Ports:
//     i_clk        clock, rising edge
//     i_wr_en      write strobe
//     i_wr_addr    write index
//     i_wr_data    write word
//     i_rd_a_addr  transmit read index  -> o_rd_a_data
//     i_rd_b_addr  compare read index   -> o_rd_b_data
module stream_host_buf
  import stream_host_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  localparam int AW    = idx_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_a_addr,
  output logic [DATA_W-1:0] o_rd_a_data,
  input  logic [AW-1:0]     i_rd_b_addr,
  output logic [DATA_W-1:0] o_rd_b_data
);

  // Sized to a power of two so every index value is legal; entries at or
  // above DEPTH are never written and never compared.
  logic [DATA_W-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_a_data = r_mem[i_rd_a_addr];
  assign o_rd_b_data = r_mem[i_rd_b_addr];

endmodule

// File: rtl/stream_host.sv
// stream_host
//   Initiator for the single-burst sample interface: buffers a block of words,
//   sends it as one gap-free valid burst, captures the returned burst and
//   checks it word-for-word against what was sent.
//
//   state  | meaning
//   IDLE   | accept loads, wait for start
//   SEND   | drive the burst (one extra cycle to drop tx_valid)
//   WAIT   | wait for rx_valid, timeout counter running
//   RECV   | capture returned words
//   REPORT | one cycle, then done pulse and back to IDLE
//
//   Ports:
//     clk, rst_n               clock, async active-low reset
//     ld_valid, ld_data        buffer load, one word per cycle (IDLE only)
//     ld_full                  buffer holds DEPTH words
//     start, clear             start transaction / abort and empty buffer
//     tx_valid, tx_data        burst toward the core
//     rx_valid, rx_data        burst returned by the core
//     busy, done               not-IDLE / one-cycle completion pulse
//     err_mismatch, err_len,   compare errors, length error, timeout
//     err_timeout
module stream_host
  import stream_host_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_full,
  input  logic              start,
  input  logic              clear,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_mismatch,
  output logic              err_len,
  output logic              err_timeout
);

  localparam int AW   = idx_w(DEPTH);
  localparam int TO_W = cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t r_state, w_next_state;

  logic [CNT_W-1:0]  r_wr_cnt, r_rd_idx, r_rx_cnt, r_err_mm;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_tx_valid, r_done, r_busy, r_err_len, r_err_to, r_ld_full;
  logic [DATA_W-1:0] r_tx_data;

  logic [CNT_W-1:0]  w_wr_cnt_d, w_rd_idx_d, w_rx_cnt_d, w_err_mm_d;
  logic [TO_W-1:0]   w_to_cnt_d;
  logic              w_tx_valid_d, w_done_d, w_err_len_d, w_err_to_d;
  logic [DATA_W-1:0] w_tx_data_d;

  logic              w_start_ok, w_wr_en, w_capture;
  logic [DATA_W-1:0] w_rd_tx, w_rd_cmp;

  // Start needs a non-empty buffer; an accepted start swallows a same-cycle load.
  assign w_start_ok = (r_state == ST_IDLE) && start && (r_wr_cnt != '0) && !clear;
  assign w_wr_en    = (r_state == ST_IDLE) && ld_valid && (r_wr_cnt != FULL_CNT)
                      && !w_start_ok && !clear;
  assign w_capture  = rx_valid && ((r_state == ST_WAIT) || (r_state == ST_RECV));

  stream_host_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .i_clk       (clk),
    .i_wr_en     (w_wr_en),
    .i_wr_addr   (r_wr_cnt[AW-1:0]),
    .i_wr_data   (ld_data),
    .i_rd_a_addr (r_rd_idx[AW-1:0]),
    .o_rd_a_data (w_rd_tx),
    .i_rd_b_addr (r_rx_cnt[AW-1:0]),
    .o_rd_b_data (w_rd_cmp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_start_ok) w_next_state = ST_SEND;
        // rd_idx == wr_cnt means every beat is out; this cycle drops tx_valid
        // so it is low for a full cycle before any rx beat is taken.
        ST_SEND:   if (r_rd_idx == r_wr_cnt) w_next_state = ST_WAIT;
        ST_WAIT: begin
          if (rx_valid)                   w_next_state = ST_RECV;
          else if (r_to_cnt == TO_LAST)   w_next_state = ST_REPORT;
        end
        ST_RECV:   if (!rx_valid) w_next_state = ST_REPORT;
        ST_REPORT: w_next_state = ST_IDLE;
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wr_cnt_d   = r_wr_cnt;
    w_rd_idx_d   = r_rd_idx;
    w_rx_cnt_d   = r_rx_cnt;
    w_err_mm_d   = r_err_mm;
    w_to_cnt_d   = r_to_cnt;
    w_tx_valid_d = 1'b0;
    w_tx_data_d  = '0;
    w_done_d     = 1'b0;
    w_err_len_d  = r_err_len;
    w_err_to_d   = r_err_to;
    if (clear) begin
      w_wr_cnt_d  = '0;
      w_rd_idx_d  = '0;
      w_rx_cnt_d  = '0;
      w_err_mm_d  = '0;
      w_to_cnt_d  = '0;
      w_err_len_d = 1'b0;
      w_err_to_d  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            w_rd_idx_d  = '0;
            w_rx_cnt_d  = '0;
            w_to_cnt_d  = '0;
            w_err_mm_d  = '0;
            w_err_len_d = 1'b0;
            w_err_to_d  = 1'b0;
          end else if (w_wr_en) begin
            w_wr_cnt_d = r_wr_cnt + CNT_W'(1);
          end
        end
        ST_SEND: begin
          if (r_rd_idx != r_wr_cnt) begin
            w_tx_valid_d = 1'b1;
            w_tx_data_d  = w_rd_tx;
            w_rd_idx_d   = r_rd_idx + CNT_W'(1);
          end else begin
            w_to_cnt_d = '0;
          end
        end
        ST_WAIT: begin
          if (!rx_valid) begin
            w_to_cnt_d = r_to_cnt + TO_W'(1);
            if (r_to_cnt == TO_LAST) w_err_to_d = 1'b1;
          end
        end
        ST_RECV: begin
          if (!rx_valid) w_err_len_d = (r_rx_cnt != r_wr_cnt);
        end
        ST_REPORT: w_done_d = 1'b1;
        default: ;
      endcase
      // Words past the sent length are counted only, never compared.
      if (w_capture) begin
        if ((r_rx_cnt < r_wr_cnt) && (rx_data != w_rd_cmp) && (r_err_mm != '1)) begin
          w_err_mm_d = r_err_mm + CNT_W'(1);
        end
        if (r_rx_cnt != '1) w_rx_cnt_d = r_rx_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt   <= '0;
      r_rd_idx   <= '0;
      r_rx_cnt   <= '0;
      r_err_mm   <= '0;
      r_to_cnt   <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_to   <= 1'b0;
      r_ld_full  <= 1'b0;
    end else begin
      r_wr_cnt   <= w_wr_cnt_d;
      r_rd_idx   <= w_rd_idx_d;
      r_rx_cnt   <= w_rx_cnt_d;
      r_err_mm   <= w_err_mm_d;
      r_to_cnt   <= w_to_cnt_d;
      r_tx_valid <= w_tx_valid_d;
      r_tx_data  <= w_tx_data_d;
      r_done     <= w_done_d;
      r_busy     <= (w_next_state != ST_IDLE);
      r_err_len  <= w_err_len_d;
      r_err_to   <= w_err_to_d;
      r_ld_full  <= (w_wr_cnt_d == FULL_CNT);
    end
  end

  assign ld_full      = r_ld_full;
  assign tx_valid     = r_tx_valid;
  assign tx_data      = r_tx_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_mismatch = r_err_mm;
  assign err_len      = r_err_len;
  assign err_timeout  = r_err_to;

endmodule

// File: tb/tb_stream_host.sv
// tb_stream_host
//   Self-checking bench for stream_host. The reference model is a queue of
//   loaded words; expected burst, mismatch count and length error are derived
//   from that queue and the echo queue driven back.
module tb_stream_host;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              start = 1'b0;
  logic              clear = 1'b0;
  logic              rx_valid = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              ld_full, tx_valid, busy, done, err_len, err_timeout;
  logic [DATA_W-1:0] tx_data;
  logic [CNT_W-1:0]  err_mismatch;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_buf[$];
  logic [15:0] m_echo[$];
  logic [15:0] m_got[$];

  int o_first, o_last, o_fall, o_done_at, o_dones;
  bit o_gapless;
  logic o_busy_done;

  stream_host #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_full      (ld_full),
    .start        (start),
    .clear        (clear),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .busy         (busy),
    .done         (done),
    .err_mismatch (err_mismatch),
    .err_len      (err_len),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  function automatic int exp_mm();
    int n = 0;
    for (int i = 0; i < m_echo.size() && i < m_buf.size(); i++)
      if (m_echo[i] !== m_buf[i]) n++;
    if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
    return n;
  endfunction

  function automatic logic exp_len();
    return (m_echo.size() != m_buf.size());
  endfunction

  // Index of first difference between sent burst and model, -1 if identical.
  function automatic int first_diff();
    int n = (m_got.size() > m_buf.size()) ? m_got.size() : m_buf.size();
    for (int i = 0; i < n; i++) begin
      if (i >= m_got.size() || i >= m_buf.size()) return i;
      if (m_got[i] !== m_buf[i]) return i;
    end
    return -1;
  endfunction

  task automatic load_seq(input int n, input bit rnd, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = rnd ? 16'($urandom) : base + 16'(i);
      if (m_buf.size() < DEPTH) m_buf.push_back(ld_data);
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_buf.delete();
  endtask

  // Start, watch the burst, echo m_echo back 'gap' cycles after tx_valid
  // falls, and record what happened until two cycles past done.
  task automatic run_txn(input int gap, input bit ld_at_start);
    int cyc;
    int ei;
    o_first = -1; o_last = -1; o_fall = -1; o_done_at = -1; o_dones = 0;
    o_gapless = 1'b1; o_busy_done = 1'b1; ei = 0;
    m_got.delete();
    @(negedge clk);
    start = 1'b1;
    if (ld_at_start) begin
      ld_valid = 1'b1;
      ld_data  = 16'hBEEF;
    end
    @(negedge clk);
    start = 1'b0;
    ld_valid = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (tx_valid) begin
        if (o_first < 0) o_first = cyc;
        else if (o_last != cyc - 1) o_gapless = 1'b0;
        o_last = cyc;
        m_got.push_back(tx_data);
      end else if (o_first >= 0 && o_fall < 0) begin
        o_fall = cyc;
      end
      if (done) begin
        o_dones++;
        if (o_done_at < 0) begin
          o_done_at   = cyc;
          o_busy_done = busy;
        end
      end
      rx_valid = 1'b0;
      rx_data  = '0;
      if (o_fall >= 0 && cyc >= o_fall + gap && ei < m_echo.size()) begin
        rx_valid = 1'b1;
        rx_data  = m_echo[ei];
        ei++;
      end
      if (o_done_at >= 0 && cyc >= o_done_at + 2) break;
      @(negedge clk);
      cyc++;
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({tx_valid, busy, done, err_len, err_timeout, ld_full} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {tx_valid, busy, done, err_len, err_timeout, ld_full});
    end
    total++;
    if (tx_data !== '0 || err_mismatch !== '0) begin
      bad++;
      $display("FAIL reset_data: tx_data=%h err_mismatch=%0d want 0 0", tx_data, err_mismatch);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_echo_match();
    do_clear();
    load_seq(4, 1'b0, 16'h0001);
    m_echo = m_buf;
    run_txn(3, 1'b0);
    total++;
    if (o_dones !== 1) begin bad++; $display("FAIL match_done: got %0d pulses want 1", o_dones); end
    total++;
    if (o_first !== 2) begin bad++; $display("FAIL match_latency: got cycle %0d want 2", o_first); end
    total++;
    if (!o_gapless || (o_last - o_first + 1) !== 4) begin
      bad++; $display("FAIL match_burst_shape: got len %0d gapless %0d want 4 1", o_last - o_first + 1, o_gapless);
    end
    total++;
    if (first_diff() !== -1) begin
      bad++; $display("FAIL match_burst_data: got %0d words want %0d, differs at %0d", m_got.size(), m_buf.size(), first_diff());
    end
    total++;
    if ({int'(err_mismatch), 30'(0), err_len, err_timeout} !== 64'd0) begin
      bad++; $display("FAIL match_errs: got mm=%0d len=%0d to=%0d want 0 0 0", err_mismatch, err_len, err_timeout);
    end
    total++;
    if (o_busy_done !== 1'b0) begin bad++; $display("FAIL match_busy_at_done: got %0d want 0", o_busy_done); end
  endtask

  task automatic test_echo_mismatch();
    m_echo.delete();
    m_echo.push_back(16'h0001); m_echo.push_back(16'hFFFF);
    m_echo.push_back(16'h0003); m_echo.push_back(16'h0000);
    run_txn(3, 1'b0);
    total++;
    if (first_diff() !== -1) begin bad++; $display("FAIL resend_data: differs at %0d want -1", first_diff()); end
    total++;
    if (int'(err_mismatch) !== exp_mm() || exp_mm() !== 2) begin
      bad++; $display("FAIL mismatch_count: got %0d want %0d", err_mismatch, exp_mm());
    end
    total++;
    if (err_len !== 1'b0 || err_timeout !== 1'b0) begin
      bad++; $display("FAIL mismatch_flags: got len=%0d to=%0d want 0 0", err_len, err_timeout);
    end
    do_clear();
    total++;
    if (err_mismatch !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL clear_flags: got mm=%0d busy=%0d want 0 0", err_mismatch, busy);
    end
  endtask

  task automatic test_len();
    do_clear();
    load_seq(3, 1'b1, 16'h0);
    m_echo = m_buf;
    m_echo.push_back(16'($urandom));
    m_echo.push_back(16'($urandom));
    run_txn(2, 1'b0);
    total++;
    if (err_len !== 1'b1 || int'(err_mismatch) !== 0) begin
      bad++; $display("FAIL len_long: got len=%0d mm=%0d want 1 0", err_len, err_mismatch);
    end
    m_echo = m_buf;
    void'(m_echo.pop_back());
    run_txn(0, 1'b0);
    total++;
    if (err_len !== 1'b1 || int'(err_mismatch) !== 0 || o_dones !== 1) begin
      bad++; $display("FAIL len_short: got len=%0d mm=%0d dones=%0d want 1 0 1", err_len, err_mismatch, o_dones);
    end
  endtask

  task automatic test_timeout();
    do_clear();
    load_seq(2, 1'b1, 16'h0);
    m_echo.delete();
    run_txn(0, 1'b0);
    total++;
    if (err_timeout !== 1'b1 || o_dones !== 1) begin
      bad++; $display("FAIL timeout_flag: got to=%0d dones=%0d want 1 1", err_timeout, o_dones);
    end
    total++;
    if (o_done_at - o_fall !== TIMEOUT + 1) begin
      bad++; $display("FAIL timeout_delay: got %0d cycles want %0d", o_done_at - o_fall, TIMEOUT + 1);
    end
    total++;
    if (err_len !== 1'b0 || err_mismatch !== '0) begin
      bad++; $display("FAIL timeout_other: got len=%0d mm=%0d want 0 0", err_len, err_mismatch);
    end
  endtask

  task automatic test_full();
    do_clear();
    load_seq(DEPTH - 1, 1'b1, 16'h0);
    total++;
    if (ld_full !== 1'b0) begin bad++; $display("FAIL full_early: got %0d want 0", ld_full); end
    load_seq(1, 1'b1, 16'h0);
    total++;
    if (ld_full !== 1'b1) begin bad++; $display("FAIL full_set: got %0d want 1", ld_full); end
    load_seq(1, 1'b1, 16'h0);
    m_echo = m_buf;
    run_txn(1, 1'b1);
    total++;
    if (m_got.size() !== DEPTH || !o_gapless) begin
      bad++; $display("FAIL full_burst_len: got %0d gapless %0d want %0d 1", m_got.size(), o_gapless, DEPTH);
    end
    total++;
    if (first_diff() !== -1 || err_mismatch !== '0 || err_len !== 1'b0) begin
      bad++; $display("FAIL full_burst_data: diff at %0d mm=%0d len=%0d want -1 0 0", first_diff(), err_mismatch, err_len);
    end
  endtask

  task automatic test_clear_mid();
    int beats = 0;
    int cnt   = 0;
    do_clear();
    load_seq(4, 1'b1, 16'h0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && beats < 2; i++) begin
      @(negedge clk);
      if (tx_valid) beats++;
    end
    total++;
    if (beats !== 2) begin bad++; $display("FAIL clear_mid_reach: got %0d beats want 2", beats); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_buf.delete();
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL clear_mid_stop: got tx_valid=%0d busy=%0d want 0 0", tx_valid, busy);
    end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done || tx_valid) cnt++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || tx_valid) cnt++;
    end
    total++;
    if (cnt !== 0) begin bad++; $display("FAIL clear_mid_quiet: got %0d active cycles want 0", cnt); end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    int cnt   = 0;
    do_clear();
    load_seq(5, 1'b1, 16'h0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && beats < 2; i++) begin
      @(negedge clk);
      if (tx_valid) beats++;
    end
    total++;
    if (beats !== 2) begin bad++; $display("FAIL reset_mid_reach: got %0d beats want 2", beats); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_async: got tx_valid=%0d busy=%0d want 0 0", tx_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_buf.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || tx_valid || done) cnt++;
    end
    total++;
    if (cnt !== 0) begin bad++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", cnt); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int n;
      int mode;
      int gap;
      bit lds;
      do_clear();
      n = $urandom_range(1, DEPTH);
      load_seq(n, 1'b1, 16'h0);
      m_echo = m_buf;
      for (int i = 0; i < n; i++)
        if ($urandom_range(0, 2) == 0) m_echo[i] = 16'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        for (int i = 0; i < $urandom_range(1, 3); i++) m_echo.push_back(16'($urandom));
      end else if (mode == 2 && n > 1) begin
        void'(m_echo.pop_back());
      end
      gap = $urandom_range(0, 4);
      lds = 1'($urandom_range(0, 1));
      for (int rep = 0; rep < 2; rep++) begin
        run_txn(gap, lds);
        total++;
        if (o_dones !== 1 || first_diff() !== -1) begin
          bad++; $display("FAIL rand_burst it%0d rep%0d: dones=%0d diff_at=%0d want 1 -1", it, rep, o_dones, first_diff());
        end
        total++;
        if (int'(err_mismatch) !== exp_mm() || err_len !== exp_len() || err_timeout !== 1'b0) begin
          bad++; $display("FAIL rand_errs it%0d rep%0d: got mm=%0d len=%0d to=%0d want %0d %0d 0",
                          it, rep, err_mismatch, err_len, err_timeout, exp_mm(), exp_len());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_echo_match();
    test_echo_mismatch();
    test_len();
    test_timeout();
    test_full();
    test_clear_mid();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
